// File: rtl/karatsuba_mult.sv
// karatsuba_mult: registered carry-less (GF(2)[x]) polynomial multiplier.
// Produces the full unreduced 2*size-bit product of two size-bit binary
// polynomials through a recursive Karatsuba decomposition. The default width
// of 163 matches the NIST B-163 field. No modular reduction is done here.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (priority over in_valid)
//   in_valid   a/b valid this cycle; the product is captured at the edge
//   a, b       size-bit operands, bit i = coefficient of x^i
//   out_valid  c holds a product captured on the previous edge
//   c          2*size-bit product; bit 2*size-1 is always 0
//
// karatsuba_core is the combinational recursive core used by the top.

// Combinational carry-less multiplier core, N x N -> 2N bits.
// Widths above THRESHOLD split into lo = ceil(N/2) and hi = N - lo halves and
// recurse; widths at or below THRESHOLD use a plain AND-XOR array.
module karatsuba_core #(
  parameter int unsigned N         = 163,
  parameter int unsigned THRESHOLD = 16
) (
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic [2*N-1:0] r_o
);

  if (N <= THRESHOLD) begin : g_leaf
    // Schoolbook: r[k] = XOR over i+j=k of a[i]&b[j].
    always_comb begin
      r_o = '0;
      for (int i = 0; i < int'(N); i++) begin
        for (int j = 0; j < int'(N); j++) begin
          r_o[i+j] = r_o[i+j] ^ (a_i[i] & b_i[j]);
        end
      end
    end
  end else begin : g_split
    localparam int unsigned LO = (N + 1) / 2;
    localparam int unsigned HI = N - LO;

    logic [LO-1:0]   al, bl, a_sum, b_sum;
    logic [HI-1:0]   ah, bh;
    logic [2*LO-1:0] p0, p1, m;
    logic [2*HI-1:0] p2;

    assign al = a_i[LO-1:0];
    assign ah = a_i[N-1:LO];
    assign bl = b_i[LO-1:0];
    assign bh = b_i[N-1:LO];

    // For odd N the high half is one bit narrower; zero-extend before folding.
    assign a_sum = al ^ LO'(ah);
    assign b_sum = bl ^ LO'(bh);

    karatsuba_core #(.N(LO), .THRESHOLD(THRESHOLD)) u_p0 (
      .a_i(al), .b_i(bl), .r_o(p0)
    );

    karatsuba_core #(.N(HI), .THRESHOLD(THRESHOLD)) u_p2 (
      .a_i(ah), .b_i(bh), .r_o(p2)
    );

    karatsuba_core #(.N(LO), .THRESHOLD(THRESHOLD)) u_p1 (
      .a_i(a_sum), .b_i(b_sum), .r_o(p1)
    );

    // Middle term: subtraction is XOR in GF(2).
    assign m = p1 ^ p0 ^ (2*LO)'(p2);

    assign r_o = ((2*N)'(p2) << (2*LO)) ^ ((2*N)'(m) << LO) ^ (2*N)'(p0);
  end

endmodule

// Top level: combinational core followed by the product/valid registers.
module karatsuba_mult #(
  parameter int unsigned size      = 163,
  parameter int unsigned THRESHOLD = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [size-1:0]     a,
  input  logic [size-1:0]     b,
  output logic                out_valid,
  output logic [2*size-1:0]   c
);

  localparam int unsigned CW = 2 * size;

  logic [CW-1:0] prod_c;
  logic [CW-1:0] c_d, c_q;
  logic          valid_d, valid_q;

  karatsuba_core #(.N(size), .THRESHOLD(THRESHOLD)) u_core (
    .a_i(a), .b_i(b), .r_o(prod_c)
  );

  // Capture on in_valid; otherwise hold, so idle X operands never reach c.
  always_comb begin
    c_d     = c_q;
    valid_d = 1'b0;
    if (in_valid) begin
      c_d     = prod_c;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      c_q     <= c_d;
      valid_q <= valid_d;
    end
  end

  assign c         = c_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_karatsuba_mult.sv
// Self-checking bench for karatsuba_mult: directed corner products plus a
// random back-to-back stream, compared against a shift-and-XOR reference.
module tb_karatsuba_mult;

  localparam int unsigned S  = 163;
  localparam int unsigned CW = 2 * S;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [S-1:0]  a, b;
  logic          out_valid;
  logic [CW-1:0] c;

  int n_checks = 0;
  int n_fail   = 0;

  karatsuba_mult #(.size(S), .THRESHOLD(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(out_valid), .c(c)
  );

  always #5 clk = ~clk;

  // Reference: carry-less product by shifting a for every set bit of b.
  function automatic logic [CW-1:0] clmul_ref(input logic [S-1:0] x, input logic [S-1:0] y);
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(S); i++) begin
      if (y[i]) r = r ^ (CW'(x) << i);
    end
    return r;
  endfunction

  function automatic logic [S-1:0] rand_op();
    logic [191:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return S'(w);
  endfunction

  task automatic check_eq(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [CW-1:0] exp_c, last_c;
  logic [S-1:0]  ones;

  initial begin
    ones     = '1;
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = ones;
    b        = ones;
    #1;

    // Reset dominates in_valid.
    step();
    step();
    check_eq("reset_c", c, '0);
    check_eq("reset_valid", CW'(out_valid), CW'(0));

    rst = 1'b0;

    // Sparse square: (x^159+1)^2 = x^318 + 1.
    a = (S'(1) << 159) | S'(1);
    b = a;
    step();
    exp_c = '0;
    exp_c[318] = 1'b1;
    exp_c[0]   = 1'b1;
    check_eq("sparse_sq", c, exp_c);
    check_eq("sparse_sq_model", c, clmul_ref(a, b));
    check_eq("sparse_sq_valid", CW'(out_valid), CW'(1));

    // Distinct operands; the x^155 cross terms cancel.
    a = (S'(1) << 155) | (S'(1) << 148) | S'(1);
    b = (S'(1) << 155) | (S'(1) << 149) | S'(1);
    step();
    exp_c = '0;
    exp_c[310] = 1'b1; exp_c[304] = 1'b1; exp_c[303] = 1'b1; exp_c[297] = 1'b1;
    exp_c[149] = 1'b1; exp_c[148] = 1'b1; exp_c[0]   = 1'b1;
    check_eq("distinct", c, exp_c);

    // Dense square of bits 0..158: squaring in GF(2) spreads to even bits.
    a = (S'(1) << 159) - S'(1);
    b = a;
    step();
    exp_c = '0;
    for (int k = 0; k <= 316; k += 2) exp_c[k] = 1'b1;
    check_eq("dense_sq", c, exp_c);

    // Full-width square, top product bit stays 0.
    a = ones;
    b = ones;
    step();
    exp_c = '0;
    for (int k = 0; k <= 324; k += 2) exp_c[k] = 1'b1;
    check_eq("full_sq", c, exp_c);
    check_eq("full_sq_top", CW'(c[CW-1]), CW'(0));

    // Zero operand.
    a = '0;
    b = rand_op();
    step();
    check_eq("zero_a", c, '0);

    // Single-bit and narrow operands across the split boundaries.
    for (int k = 0; k < 8; k++) begin
      a = S'(1) << $urandom_range(S - 1, 0);
      b = rand_op() >> $urandom_range(S - 1, 0);
      step();
      check_eq("edge_rand", c, clmul_ref(a, b));
    end

    // Back-to-back random stream.
    for (int k = 0; k < 1000; k++) begin
      a = rand_op();
      b = rand_op();
      step();
      check_eq("stream", c, clmul_ref(a, b));
      if (out_valid !== 1'b1) check_eq("stream_valid", CW'(out_valid), CW'(1));
    end
    last_c = clmul_ref(a, b);

    // Idle: product holds and valid drops while the operands keep changing.
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a = rand_op();
      b = rand_op();
      step();
      check_eq("hold_c", c, last_c);
      check_eq("hold_valid", CW'(out_valid), CW'(0));
    end

    // Reset after data clears the product, even with in_valid high.
    rst      = 1'b1;
    in_valid = 1'b1;
    step();
    check_eq("rst_after_data_c", c, '0);
    check_eq("rst_after_data_valid", CW'(out_valid), CW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
